// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and elaboration helpers for the sequential binary-to-BCD converter.
//   BCD_DIGIT_W     width of one packed BCD digit
//   bcd_state_t     controller states IDLE -> SHIFT -> DONE
//   bcd_cnt_w()     width of the shift counter for a given binary width
//   bcd_min_digits() decimal digits needed to hold 2**bin_w-1
package bcd_pkg;
    localparam int BCD_DIGIT_W = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} bcd_state_t;
    function automatic int bcd_cnt_w(input int bin_w);
        return (bin_w > 1) ? $clog2(bin_w) : 1;
    endfunction
    function automatic int bcd_min_digits(input int bin_w);
        longint unsigned v;
        int d;
        v = (64'd1 << bin_w) - 64'd1;
        d = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            d++;
        end
        return d;
    endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to a BCD digit of 5 or more.
//   d_in   in   4  digit before the shift
//   d_out  out  4  corrected digit (4-bit wrap, no carry out)
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d_in,
    output logic [BCD_DIGIT_W-1:0] d_out
);
    always_comb d_out = (d_in >= 4'd5) ? d_in + 4'd3 : d_in;
endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// bin2bcd_seq_ctrl: sequential shift-and-add-3 binary-to-BCD converter, one bit per cycle, ready/valid both sides.
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous active-high reset
//   in_valid   in   1          in_bin valid
//   in_ready   out  1          converter idle, can accept
//   in_bin     in   BIN_W      unsigned operand, sampled only on the accept edge
//   out_valid  out  1          out_bcd holds a completed result
//   out_ready  in   1          consumer accepts result
//   out_bcd    out  4*DIGITS   packed BCD, digit 0 in [3:0]
//   out_lz     out  DIGITS     leading-zero mask; driven only when BIN2BCD_LZ_MASK_EN is defined, else tied 0
module bin2bcd_seq_ctrl
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic [DIGITS-1:0]             out_lz
);
    localparam int CNT_W = bcd_cnt_w(BIN_W);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    if (BIN_W < 4 || BIN_W > 32) begin : g_bad_bin_w
        $error("bin2bcd_seq_ctrl: BIN_W must be 4..32");
    end
    if (DIGITS < bcd_min_digits(BIN_W)) begin : g_bad_digits
        $error("bin2bcd_seq_ctrl: DIGITS too small for BIN_W");
    end

    bcd_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIN_W-1:0]       bin_sr_q, bin_sr_d;
    logic [BCD_W-1:0]       bcd_sr_q, bcd_sr_d, out_bcd_q, out_bcd_d, adj;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic                   done_entry;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_in (bcd_sr_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .d_out(adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    // Corrected digits and the binary word shift together as one register.
    assign shifted    = {adj, bin_sr_q} << 1;
    assign done_entry = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_bcd    = out_bcd_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_sr_d  = bin_sr_q;
        bcd_sr_d  = bcd_sr_q;
        out_bcd_d = out_bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d  = ST_SHIFT;
                    bin_sr_d = in_bin;
                    bcd_sr_d = '0;
                    cnt_d    = '0;
                end
            end
            ST_SHIFT: begin
                {bcd_sr_d, bin_sr_d} = shifted;
                cnt_d                = cnt_q + 1'b1;
                if (done_entry) begin
                    state_d   = ST_DONE;
                    out_bcd_d = shifted[BCD_W+BIN_W-1:BIN_W];
                end
            end
            ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bin_sr_q  <= '0;
            bcd_sr_q  <= '0;
            out_bcd_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_sr_q  <= bin_sr_d;
            bcd_sr_q  <= bcd_sr_d;
            out_bcd_q <= out_bcd_d;
        end
    end

`ifdef BIN2BCD_LZ_MASK_EN
    logic [DIGITS-1:0] lz_q, lz_d, lz_calc;
    logic              lz_run;

    // Scan from the top digit down; digit 0 is never masked so zero shows as "0".
    always_comb begin
        lz_run  = 1'b1;
        lz_calc = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_run     = lz_run && (out_bcd_d[BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0);
            lz_calc[i] = lz_run;
        end
        lz_d = done_entry ? lz_calc : lz_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lz_q <= '0;
        else     lz_q <= lz_d;
    end

    assign out_lz = lz_q;
`else
    assign out_lz = '0;
`endif
endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
module tb_bin2bcd_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_bin;
    logic [11:0] out_bcd;
    logic [2:0]  out_lz;
    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [15:0] w_in_bin;
    logic [19:0] w_out_bcd;
    logic [4:0]  w_out_lz;

    typedef struct {
        logic [11:0] bcd;
        logic [2:0]  lz;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cnt  = 0;
    int   last_acc = 0;
    int   prev_acc = 0;
    logic prev_ov  = 1'b0;

    always #5 clk = ~clk;

    bin2bcd_seq_ctrl #(.BIN_W(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
        .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .out_lz(out_lz)
    );

    bin2bcd_seq_ctrl #(.BIN_W(16), .DIGITS(5)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_bin(w_in_bin),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_bcd(w_out_bcd), .out_lz(w_out_lz)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Decimal digits by repeated division.
    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int nd);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(v % 64'd10);
            v = v / 64'd10;
        end
        return r;
    endfunction

    // Digits at or above the count of significant decimal digits are masked.
    function automatic logic [63:0] ref_lz(input longint unsigned v, input int nd);
        logic [63:0] r;
        r = '0;
`ifdef BIN2BCD_LZ_MASK_EN
        begin
            int nsig;
            nsig = 1;
            while (v >= 64'd10) begin
                v = v / 64'd10;
                nsig++;
            end
            for (int i = nsig; i < nd; i++) r[i] = 1'b1;
        end
`endif
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            sb.delete();
            prev_ov <= 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) check("unexpected_out_valid", 64'(out_valid), 64'd0);
                else                check("latency", 64'(cyc - sb[0].acc), 64'd8);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check("out_bcd", 64'(out_bcd), 64'(e.bcd));
                check("out_lz", 64'(out_lz), 64'(e.lz));
            end
            if (in_valid && in_ready) begin
                sb.push_back('{bcd: 12'(ref_bcd(64'(in_bin), 3)), lz: 3'(ref_lz(64'(in_bin), 3)), acc: cyc + 1});
                prev_acc <= last_acc;
                last_acc <= cyc + 1;
                acc_cnt  <= acc_cnt + 1;
            end
            prev_ov <= out_valid;
        end
    end

    task automatic send(input logic [7:0] v);
        int n;
        in_bin   = v;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bin   = 8'hxx;
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (acc_cnt < target && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (acc_cnt < target) check("accept_timeout", 64'(acc_cnt), 64'(target));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_w(input logic [15:0] v);
        int n;
        w_in_bin   = v;
        w_in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!w_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!w_out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!w_out_valid) check("w_out_timeout", 64'(w_out_valid), 64'd1);
        else begin
            check("w_out_bcd", 64'(w_out_bcd), ref_bcd(64'(v), 5));
            check("w_out_lz", 64'(w_out_lz), ref_lz(64'(v), 5));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid    = 1'b0;
        in_bin      = '0;
        out_ready   = 1'b1;
        w_in_valid  = 1'b0;
        w_in_bin    = '0;
        w_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_bcd", 64'(out_bcd), 64'd0);
        check("rst_out_lz", 64'(out_lz), 64'd0);
        check("rst_w_in_ready", 64'(w_in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(8'd255);
        drain();
        send(8'd0);
        drain();
        in_bin   = 8'd99;
        in_valid = 1'b1;
        wait_acc(acc_cnt + 1);
        in_bin = 8'd100;
        wait_acc(acc_cnt + 1);
        in_valid = 1'b0;
        check("accept_spacing", 64'(last_acc - prev_acc), 64'd10);
        drain();
        out_ready = 1'b0;
        send(8'd173);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 30) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (20) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_bcd", 64'(out_bcd), 64'h173);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_bin   = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
        send(8'd200);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #6;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        repeat (15) @(negedge clk);
        check("post_rst_quiet", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        send(8'd7);
        drain();
        for (int v = 0; v < 256; v++) send(8'(v));
        repeat (20) send(8'($urandom_range(0, 255)));
        drain();
        send_w(16'd65535);
        send_w(16'd0);
        send_w(16'd10000);
        send_w(16'd54321);
        repeat (4) send_w(16'($urandom_range(0, 65535)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
